// File: rtl/fwd_bypass_stage_pkg.sv
// Shared types for the operand forwarding / bypass stage.
//   fwd_sel_e : where an operand was finally sourced from
//   cdb_t     : one CDB broadcast slot {valid, tag, data} at the default
//               machine widths (the stage itself stores history as packed
//               arrays sized by its own parameters)
package fwd_bypass_stage_pkg;

  localparam int CDB_DATA_LEN  = 32;
  localparam int CDB_ROBID_LEN = 6;

  typedef enum logic [1:0] {
    PRF_DATA_READ = 2'd0,
    CDB_LIVE      = 2'd1,
    CDB_HIST      = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                     v;
    logic [CDB_ROBID_LEN-1:0] robid;
    logic [CDB_DATA_LEN-1:0]  data;
  } cdb_t;

endpackage

// File: rtl/fwd_bypass_stage_src_sel.sv
// fwd_src_sel: priority select for one source operand.
//   src_prf=1   -> prf_data
//   src_prf=0   -> live CDB, then history age 1 .. HIST_DEPTH;
//                  inside one age the lowest CDB lane wins.
// Ports: src_prf/src_robid/prf_data (operand request), cdb_* (live bus),
//        hist_* (index 0 = age 1), data/hit/found (result; hit = came
//        from CDB or history, found = operand resolved).
module fwd_src_sel
  import fwd_bypass_stage_pkg::*;
#(
  parameter int CDB_NUM_LANES = 4,
  parameter int DATA_LEN      = 32,
  parameter int ROBID_LEN     = 6,
  parameter int HIST_DEPTH    = 2
) (
  input  logic                                                   src_prf,
  input  logic [ROBID_LEN-1:0]                                   src_robid,
  input  logic [DATA_LEN-1:0]                                    prf_data,
  input  logic [CDB_NUM_LANES-1:0]                               cdb_v,
  input  logic [CDB_NUM_LANES-1:0][ROBID_LEN-1:0]                cdb_robid,
  input  logic [CDB_NUM_LANES-1:0][DATA_LEN-1:0]                 cdb_data,
  input  logic [HIST_DEPTH-1:0][CDB_NUM_LANES-1:0]               hist_v,
  input  logic [HIST_DEPTH-1:0][CDB_NUM_LANES-1:0][ROBID_LEN-1:0] hist_robid,
  input  logic [HIST_DEPTH-1:0][CDB_NUM_LANES-1:0][DATA_LEN-1:0] hist_data,
  output logic [DATA_LEN-1:0]                                    data,
  output logic                                                   hit,
  output logic                                                   found
);

  fwd_sel_e sel;

  // Scan lowest priority first so later (higher priority) matches overwrite:
  // oldest age -> newest age -> live, and high lane -> low lane in each.
  always_comb begin
    sel   = PRF_DATA_READ;
    data  = '0;
    found = 1'b0;
    if (src_prf) begin
      data  = prf_data;
      found = 1'b1;
    end else begin
      for (int a = HIST_DEPTH-1; a >= 0; a--) begin
        for (int l = CDB_NUM_LANES-1; l >= 0; l--) begin
          if (hist_v[a][l] && (hist_robid[a][l] == src_robid)) begin
            data  = hist_data[a][l];
            found = 1'b1;
            sel   = CDB_HIST;
          end
        end
      end
      for (int l = CDB_NUM_LANES-1; l >= 0; l--) begin
        if (cdb_v[l] && (cdb_robid[l] == src_robid)) begin
          data  = cdb_data[l];
          found = 1'b1;
          sel   = CDB_LIVE;
        end
      end
    end
  end

  assign hit = (sel != PRF_DATA_READ);

endmodule

// File: rtl/fwd_bypass_stage.sv
// fwd_bypass_stage: operand forwarding into EX1.
// Each issue lane's source operands come from the PRF read port or, if the
// value was not yet in the PRF, from the live CDB or a short CDB history.
// A lane with an unresolved operand is dropped (ex1_v=0) and fwd_miss pulses
// so the RS can replay it. One cycle fwd->ex1 latency; stall holds EX1,
// flush kills it. hit_cnt saturates at all-ones.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   fwd_*               issue-side request per lane / per operand
//   prf_rdata           PRF read data, port ln*NUM_SRCS+s
//   cdb_*               live CDB broadcast
//   stall, flush        EX1 hold / kill;  fwd_ready = ~stall
//   ex1_*               registered EX1 operands and pass-through fields
//   fwd_miss            one-cycle pulse per lane with an unresolved operand
//   hit_cnt             operands sourced from CDB or history
module fwd_bypass_stage
  import fwd_bypass_stage_pkg::*;
#(
  parameter int CPU_NUM_LANES = 4,
  parameter int NUM_SRCS      = 2,
  parameter int CDB_NUM_LANES = 4,
  parameter int DATA_LEN      = 32,
  parameter int ROBID_LEN     = 6,
  parameter int HIST_DEPTH    = 2,
  parameter int CTRL_W        = 8,
  parameter int CNT_W         = 32
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [CPU_NUM_LANES-1:0]                              fwd_v,
  input  logic [CPU_NUM_LANES-1:0][ROBID_LEN-1:0]               fwd_robid,
  input  logic [CPU_NUM_LANES-1:0][CTRL_W-1:0]                  fwd_ctrl,
  input  logic [CPU_NUM_LANES-1:0][NUM_SRCS-1:0][ROBID_LEN-1:0] fwd_src_robid,
  input  logic [CPU_NUM_LANES-1:0][NUM_SRCS-1:0]                fwd_src_prf,
  input  logic [CPU_NUM_LANES*NUM_SRCS-1:0][DATA_LEN-1:0]       prf_rdata,
  input  logic [CDB_NUM_LANES-1:0]                              cdb_v,
  input  logic [CDB_NUM_LANES-1:0][ROBID_LEN-1:0]               cdb_robid,
  input  logic [CDB_NUM_LANES-1:0][DATA_LEN-1:0]                cdb_data,
  input  logic                                                  stall,
  input  logic                                                  flush,
  output logic                                                  fwd_ready,
  output logic [CPU_NUM_LANES-1:0]                              ex1_v,
  output logic [CPU_NUM_LANES-1:0][NUM_SRCS-1:0][DATA_LEN-1:0]  ex1_src_data,
  output logic [CPU_NUM_LANES-1:0][ROBID_LEN-1:0]               ex1_robid,
  output logic [CPU_NUM_LANES-1:0][CTRL_W-1:0]                  ex1_ctrl,
  output logic [CPU_NUM_LANES-1:0]                              fwd_miss,
  output logic [CNT_W-1:0]                                      hit_cnt
);

  localparam int ADD_W = $clog2(CPU_NUM_LANES*NUM_SRCS+1);
  localparam int SUM_W = CNT_W + ADD_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // CDB history, index 0 = age 1 (previous cycle).
  logic [HIST_DEPTH-1:0][CDB_NUM_LANES-1:0]                hist_v;
  logic [HIST_DEPTH-1:0][CDB_NUM_LANES-1:0][ROBID_LEN-1:0] hist_robid;
  logic [HIST_DEPTH-1:0][CDB_NUM_LANES-1:0][DATA_LEN-1:0]  hist_data;

  logic [CPU_NUM_LANES-1:0][NUM_SRCS-1:0][DATA_LEN-1:0] sel_data;
  logic [CPU_NUM_LANES-1:0][NUM_SRCS-1:0]               sel_hit;
  logic [CPU_NUM_LANES-1:0][NUM_SRCS-1:0]               sel_found;
  logic [CPU_NUM_LANES-1:0]                             lane_ok;
  logic [ADD_W-1:0]                                     hit_add;
  logic [SUM_W-1:0]                                     cnt_sum;
  logic [CNT_W-1:0]                                     cnt_next;

  assign fwd_ready = ~stall;

  for (genvar ln = 0; ln < CPU_NUM_LANES; ln++) begin : g_lane
    for (genvar s = 0; s < NUM_SRCS; s++) begin : g_src
      fwd_src_sel #(
        .CDB_NUM_LANES (CDB_NUM_LANES),
        .DATA_LEN      (DATA_LEN),
        .ROBID_LEN     (ROBID_LEN),
        .HIST_DEPTH    (HIST_DEPTH)
      ) u_sel (
        .src_prf    (fwd_src_prf[ln][s]),
        .src_robid  (fwd_src_robid[ln][s]),
        .prf_data   (prf_rdata[ln*NUM_SRCS+s]),
        .cdb_v      (cdb_v),
        .cdb_robid  (cdb_robid),
        .cdb_data   (cdb_data),
        .hist_v     (hist_v),
        .hist_robid (hist_robid),
        .hist_data  (hist_data),
        .data       (sel_data[ln][s]),
        .hit        (sel_hit[ln][s]),
        .found      (sel_found[ln][s])
      );
    end
    assign lane_ok[ln] = &sel_found[ln];
  end

  // Bypass hits from valid lanes; a lane dropped for a miss on another
  // operand still counts the operands it did find.
  always_comb begin
    hit_add = '0;
    for (int ln = 0; ln < CPU_NUM_LANES; ln++)
      for (int s = 0; s < NUM_SRCS; s++)
        if (fwd_v[ln] && sel_hit[ln][s]) hit_add = hit_add + ADD_W'(1);
  end

  assign cnt_sum  = {{ADD_W{1'b0}}, hit_cnt} + {{CNT_W{1'b0}}, hit_add};
  assign cnt_next = (cnt_sum > {{ADD_W{1'b0}}, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];

  // History shifts every cycle regardless of stall/flush so a producer's
  // broadcast stays visible to a replayed consumer for HIST_DEPTH cycles.
  always_ff @(posedge clk) begin
    hist_robid[0] <= cdb_robid;
    hist_data[0]  <= cdb_data;
    for (int a = 1; a < HIST_DEPTH; a++) begin
      hist_robid[a] <= hist_robid[a-1];
      hist_data[a]  <= hist_data[a-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_v       <= '0;
      ex1_v        <= '0;
      ex1_src_data <= '0;
      ex1_robid    <= '0;
      ex1_ctrl     <= '0;
      fwd_miss     <= '0;
      hit_cnt      <= '0;
    end else begin
      hist_v[0] <= cdb_v;
      for (int a = 1; a < HIST_DEPTH; a++) hist_v[a] <= hist_v[a-1];

      fwd_miss <= '0;
      if (flush) begin
        ex1_v <= '0;
      end else if (!stall) begin
        ex1_v     <= fwd_v & lane_ok;
        fwd_miss  <= fwd_v & ~lane_ok;
        ex1_robid <= fwd_robid;
        ex1_ctrl  <= fwd_ctrl;
        hit_cnt   <= cnt_next;
        for (int ln = 0; ln < CPU_NUM_LANES; ln++)
          ex1_src_data[ln] <= (fwd_v[ln] && lane_ok[ln]) ? sel_data[ln] : '0;
      end
    end
  end

endmodule

// File: tb/tb_fwd_bypass_stage.sv
module tb_fwd_bypass_stage;

  localparam int L  = 4;
  localparam int S  = 2;
  localparam int C  = 4;
  localparam int D  = 32;
  localparam int R  = 6;
  localparam int H  = 2;
  localparam int CW = 8;
  localparam int NW = 6;   // small counter so saturation is reachable

  logic                       clk = 1'b0;
  logic                       rst;
  logic [L-1:0]               fwd_v;
  logic [L-1:0][R-1:0]        fwd_robid;
  logic [L-1:0][CW-1:0]       fwd_ctrl;
  logic [L-1:0][S-1:0][R-1:0] fwd_src_robid;
  logic [L-1:0][S-1:0]        fwd_src_prf;
  logic [L*S-1:0][D-1:0]      prf_rdata;
  logic [C-1:0]               cdb_v;
  logic [C-1:0][R-1:0]        cdb_robid;
  logic [C-1:0][D-1:0]        cdb_data;
  logic                       stall;
  logic                       flush;
  logic                       fwd_ready;
  logic [L-1:0]               ex1_v;
  logic [L-1:0][S-1:0][D-1:0] ex1_src_data;
  logic [L-1:0][R-1:0]        ex1_robid;
  logic [L-1:0][CW-1:0]       ex1_ctrl;
  logic [L-1:0]               fwd_miss;
  logic [NW-1:0]              hit_cnt;

  int nvec = 0;
  int nerr = 0;

  fwd_bypass_stage #(
    .CPU_NUM_LANES (L), .NUM_SRCS (S), .CDB_NUM_LANES (C), .DATA_LEN (D),
    .ROBID_LEN (R), .HIST_DEPTH (H), .CTRL_W (CW), .CNT_W (NW)
  ) dut (
    .clk (clk), .rst (rst),
    .fwd_v (fwd_v), .fwd_robid (fwd_robid), .fwd_ctrl (fwd_ctrl),
    .fwd_src_robid (fwd_src_robid), .fwd_src_prf (fwd_src_prf),
    .prf_rdata (prf_rdata),
    .cdb_v (cdb_v), .cdb_robid (cdb_robid), .cdb_data (cdb_data),
    .stall (stall), .flush (flush), .fwd_ready (fwd_ready),
    .ex1_v (ex1_v), .ex1_src_data (ex1_src_data), .ex1_robid (ex1_robid),
    .ex1_ctrl (ex1_ctrl), .fwd_miss (fwd_miss), .hit_cnt (hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    fwd_v = '0; fwd_robid = '0; fwd_ctrl = '0;
    fwd_src_robid = '0; fwd_src_prf = '0; prf_rdata = '0;
    cdb_v = '0; cdb_robid = '0; cdb_data = '0;
    stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    // reset
    rst = 1'b1;
    idle();
    tick(); tick();
    chk("rst_ex1_v",  ex1_v, 0);
    chk("rst_data",   ex1_src_data, 0);
    chk("rst_miss",   fwd_miss, 0);
    chk("rst_cnt",    hit_cnt, 0);
    chk("rst_ready",  fwd_ready, 1);
    rst = 1'b0;

    // live CDB forward, lane0 src0 from CDB lane 2, src1 from PRF
    fwd_v = 4'b0001; fwd_robid[0] = 6'd3; fwd_ctrl[0] = 8'h5A;
    fwd_src_robid[0][0] = 6'd5; fwd_src_prf[0] = 2'b10; prf_rdata[1] = 32'h77;
    cdb_v = 4'b0100; cdb_robid[2] = 6'd5; cdb_data[2] = 32'hDEAD_BEEF;
    tick();
    chk("live_v",     ex1_v, 4'b0001);
    chk("live_s0",    ex1_src_data[0][0], 32'hDEAD_BEEF);
    chk("live_s1",    ex1_src_data[0][1], 32'h77);
    chk("live_robid", ex1_robid[0], 6'd3);
    chk("live_ctrl",  ex1_ctrl[0], 8'h5A);
    chk("live_cnt",   hit_cnt, 1);

    // live beats history, then age 1, then age 2
    fwd_v = 4'b0000;
    cdb_v = 4'b0001; cdb_robid[0] = 6'd5; cdb_data[0] = 32'h11;
    tick();
    fwd_v = 4'b0001; cdb_data[0] = 32'h22;
    tick();
    chk("prio_live",  ex1_src_data[0][0], 32'h22);
    chk("prio_cnt",   hit_cnt, 2);
    cdb_v = '0;
    tick();
    chk("hist_age1",  ex1_src_data[0][0], 32'h22);
    tick();
    chk("hist_age2",  ex1_src_data[0][0], 32'h22);
    chk("hist_cnt",   hit_cnt, 4);

    // two CDB lanes with the same tag: lowest lane wins, live and history
    idle();
    fwd_v = 4'b0010; fwd_src_prf[1] = 2'b01; prf_rdata[2] = 32'h100;
    fwd_src_robid[1][1] = 6'd9;
    cdb_v = 4'b1010; cdb_robid[1] = 6'd9; cdb_data[1] = 32'hA;
    cdb_robid[3] = 6'd9; cdb_data[3] = 32'hB;
    tick();
    chk("lowlane_v",  ex1_v, 4'b0010);
    chk("lowlane_d",  ex1_src_data[1][1], 32'hA);
    chk("lowlane_p",  ex1_src_data[1][0], 32'h100);
    cdb_v = '0;
    tick();
    chk("lowhist_d",  ex1_src_data[1][1], 32'hA);
    chk("lowhist_cnt", hit_cnt, 6);

    // unresolved operand: drop lane, pulse miss, no count
    idle();
    tick(); tick();
    fwd_v = 4'b0100; fwd_src_prf[2] = 2'b10; fwd_src_robid[2][0] = 6'd7;
    prf_rdata[5] = 32'h55;
    tick();
    chk("miss_v",     ex1_v, 0);
    chk("miss_pulse", fwd_miss, 4'b0100);
    chk("miss_data",  ex1_src_data[2], 0);
    chk("miss_cnt",   hit_cnt, 6);
    idle();
    tick();
    chk("miss_clear", fwd_miss, 0);

    // stall holds EX1, flush during stall kills it
    fwd_v = 4'b0001; fwd_src_prf[0] = 2'b11;
    prf_rdata[0] = 32'h1234; prf_rdata[1] = 32'h5678;
    fwd_robid[0] = 6'h2A; fwd_ctrl[0] = 8'hC3;
    tick();
    chk("pre_stall_d", ex1_src_data[0][0], 32'h1234);
    stall = 1'b1; fwd_v = 4'b1111; fwd_src_prf = '0;
    prf_rdata[0] = 32'hFFFF; fwd_robid[0] = 6'd1;
    cdb_v = 4'b0001; cdb_robid[0] = 6'd0; cdb_data[0] = 32'hBAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_v",     ex1_v, 4'b0001);
      chk("stall_d",     ex1_src_data[0][0], 32'h1234);
      chk("stall_robid", ex1_robid[0], 6'h2A);
      chk("stall_cnt",   hit_cnt, 6);
      chk("stall_ready", fwd_ready, 0);
      chk("stall_miss",  fwd_miss, 0);
      // later cycles present unresolvable tags that must not report a miss
      cdb_v = '0;
      for (int ln = 0; ln < L; ln++)
        for (int s = 0; s < S; s++) fwd_src_robid[ln][s] = 6'd7;
    end
    flush = 1'b1;
    tick();
    chk("flush_v",    ex1_v, 0);
    chk("flush_miss", fwd_miss, 0);
    chk("flush_cnt",  hit_cnt, 6);

    // counter saturation: 8 bypassed operands per cycle from zero
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fwd_v = 4'b1111;
    for (int ln = 0; ln < L; ln++)
      for (int s = 0; s < S; s++) fwd_src_robid[ln][s] = 6'd20;
    cdb_v = 4'b0001; cdb_robid[0] = 6'd20; cdb_data[0] = 32'hCAFE;
    for (int i = 0; i < 7; i++) tick();
    chk("sat_56",     hit_cnt, 56);
    tick();
    chk("sat_max",    hit_cnt, 63);
    chk("sat_v",      ex1_v, 4'b1111);
    chk("sat_d",      ex1_src_data[3][1], 32'hCAFE);
    tick();
    chk("sat_hold",   hit_cnt, 63);

    // reset overrides stall/flush and clears everything including history
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    tick();
    chk("rst2_v",     ex1_v, 0);
    chk("rst2_data",  ex1_src_data, 0);
    chk("rst2_robid", ex1_robid, 0);
    chk("rst2_ctrl",  ex1_ctrl, 0);
    chk("rst2_miss",  fwd_miss, 0);
    chk("rst2_cnt",   hit_cnt, 0);
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    cdb_v = '0; fwd_v = 4'b0001;
    tick();
    chk("empty_hist_v",    ex1_v, 0);
    chk("empty_hist_miss", fwd_miss, 4'b0001);
    chk("empty_hist_cnt",  hit_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
